mux_sel_sequencer: RTL and testbench

Upstream driver for the team's mux_8x1. It accepts a WIDTH-bit word over a valid/ready handshake and holds it on mux_in. It then steps sel through every index, one index every HOLD cycles, so the downstream mux emits the word serially on y. Flags mark the first and last index of each frame, back-to-back frames run with no bubble, and an abort input cancels a frame in flight.

---
 rtl/mux_sel_sequencer.sv | 71 +++++++
 tb/tb_mux_sel_sequencer.sv | 130 +++++++++++++
 2 files changed

// File: rtl/mux_sel_sequencer.sv
// mux_sel_sequencer: accepts a word and steps a mux select across it so the mux emits it serially
module mux_sel_sequencer #(
  parameter int WIDTH = 8,
  parameter int SEL_W = 3,
  parameter int HOLD = 1,
  parameter int MSB_FIRST = 0
)(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             s_valid,
  input  logic [WIDTH-1:0] s_data,
  output logic             s_ready,
  input  logic             abort,
  output logic [WIDTH-1:0] mux_in,
  output logic [SEL_W-1:0] sel,
  output logic             sel_valid,
  output logic             first,
  output logic             last
);
  localparam int HW = HOLD > 1 ? $clog2(HOLD) : 1;
  localparam logic [SEL_W-1:0] START = MSB_FIRST != 0 ? SEL_W'(WIDTH-1) : '0;
  localparam logic [SEL_W-1:0] STOP = MSB_FIRST != 0 ? '0 : SEL_W'(WIDTH-1);
  localparam logic [HW-1:0] HMAX = HW'(HOLD-1);
  typedef enum logic {IDLE, RUN} state_t;
  state_t state_q, state_d;
  logic [WIDTH-1:0] mux_in_q, mux_in_d;
  logic [SEL_W-1:0] sel_q, sel_d, sel_step;
  logic [HW-1:0] hold_q, hold_d;
  logic sel_valid_q, sel_valid_d, first_q, first_d, last_q, last_d;
  logic fin, load, drop;
  // s_ready depends only on abort and state; a load in the final frame cycle reloads with no bubble
  always_comb begin
    fin = state_q == RUN && sel_q == STOP && hold_q == HMAX;
    s_ready = !abort && (state_q == IDLE || fin);
    load = s_valid && s_ready;
    drop = abort || (fin && !load);
    sel_step = MSB_FIRST != 0 ? sel_q - 1'b1 : sel_q + 1'b1;
    state_d = drop ? IDLE : load ? RUN : state_q;
    mux_in_d = load ? s_data : mux_in_q;
    sel_d = drop ? '0 : load ? START : (state_q == RUN && hold_q == HMAX) ? sel_step : sel_q;
    hold_d = (drop || load || hold_q == HMAX) ? '0 : state_q == RUN ? hold_q + 1'b1 : hold_q;
    sel_valid_d = state_d == RUN;
    first_d = state_d == RUN && sel_d == START;
    last_d = state_d == RUN && sel_d == STOP;
  end
  // registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      mux_in_q <= '0;
      sel_q <= '0;
      hold_q <= '0;
      sel_valid_q <= 1'b0;
      first_q <= 1'b0;
      last_q <= 1'b0;
    end else begin
      state_q <= state_d;
      mux_in_q <= mux_in_d;
      sel_q <= sel_d;
      hold_q <= hold_d;
      sel_valid_q <= sel_valid_d;
      first_q <= first_d;
      last_q <= last_d;
    end
  end
  assign mux_in = mux_in_q;
  assign sel = sel_q;
  assign sel_valid = sel_valid_q;
  assign first = first_q;
  assign last = last_q;
endmodule

// File: tb/tb_mux_sel_sequencer.sv
// tb_mux_sel_sequencer: three parameterisations against a frame-position reference model
module tb_mux_sel_sequencer;
  logic clk = 1'b0;
  logic rst_n, s_valid, abort;
  logic [7:0] s_data;
  logic [2:0][7:0] mi;
  logic [2:0][2:0] sl;
  logic [2:0] vr, fs, ls, rd;
  int errs = 0, checks = 0;
  bit run [3];
  int pos [3];
  logic [7:0] word [3];
  logic [7:0] ycap;
  int vrun, vmax, lastn;
  always #5 clk = ~clk;
  for (genvar g = 0; g < 3; g++) begin : u
    mux_sel_sequencer #(.WIDTH(8), .SEL_W(3), .HOLD(g == 1 ? 3 : 1), .MSB_FIRST(g == 2 ? 1 : 0)) dut (
      .clk(clk), .rst_n(rst_n), .s_valid(s_valid), .s_data(s_data), .s_ready(rd[g]), .abort(abort),
      .mux_in(mi[g]), .sel(sl[g]), .sel_valid(vr[g]), .first(fs[g]), .last(ls[g])
    );
  end
  function automatic int hd(input int i);
    return i == 1 ? 3 : 1;
  endfunction
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  task automatic step(input logic v, input logic [7:0] d, input logic a = 1'b0, input logic r = 1'b1);
    bit er [3];
    int k, es;
    s_valid = v;
    s_data = d;
    abort = a;
    rst_n = r;
    #1;
    for (int i = 0; i < 3; i++) begin
      er[i] = !a && (!run[i] || pos[i] == 8 * hd(i) - 1);
      chk($sformatf("s_ready%0d", i), 32'(rd[i]), 32'(er[i]));
    end
    @(posedge clk);
    for (int i = 0; i < 3; i++) begin
      if (!r) begin
        run[i] = 0;
        pos[i] = 0;
        word[i] = 8'h00;
      end else if (a) begin
        run[i] = 0;
        pos[i] = 0;
      end else if (v && er[i]) begin
        run[i] = 1;
        pos[i] = 0;
        word[i] = d;
      end else if (run[i]) begin
        if (pos[i] == 8 * hd(i) - 1) begin
          run[i] = 0;
          pos[i] = 0;
        end else pos[i]++;
      end
    end
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      k = pos[i] / hd(i);
      es = run[i] ? (i == 2 ? 7 - k : k) : 0;
      chk($sformatf("mux_in%0d", i), 32'(mi[i]), 32'(word[i]));
      chk($sformatf("sel%0d", i), 32'(sl[i]), 32'(es));
      chk($sformatf("sel_valid%0d", i), 32'(vr[i]), 32'(run[i]));
      chk($sformatf("first%0d", i), 32'(fs[i]), 32'(run[i] && k == 0));
      chk($sformatf("last%0d", i), 32'(ls[i]), 32'(run[i] && k == 7));
      if (run[i]) chk($sformatf("y%0d", i), 32'(mi[i][sl[i]]), 32'(word[i][es]));
    end
    if (vr[0]) begin
      ycap[sl[0]] = mi[0][sl[0]];
      vrun++;
    end else vrun = 0;
    if (vrun > vmax) vmax = vrun;
    if (ls[1]) lastn++;
  endtask
  initial begin
    for (int i = 0; i < 3; i++) word[i] = 8'h00;
    rst_n = 1'b0;
    s_valid = 1'b0;
    abort = 1'b0;
    s_data = 8'h00;
    repeat (2) @(negedge clk);
    step(0, 8'h00, 0, 0);
    step(0, 8'h00);
    ycap = 8'h00;
    step(1, 8'hA5);
    repeat (8) step(0, 8'h00);
    chk("y_serial_a5", 32'(ycap), 32'h0A5);
    repeat (20) step(0, 8'h00);
    vrun = 0;
    vmax = 0;
    step(1, 8'hA5);
    repeat (8) step(1, 8'h3C);
    repeat (30) step(0, 8'h00);
    chk("b2b_valid_run", 32'(vmax), 32'd16);
    lastn = 0;
    step(1, 8'hF0);
    repeat (26) step(0, 8'h00);
    chk("hold3_last_cycles", 32'(lastn), 32'd3);
    step(1, 8'h01);
    repeat (9) step(0, 8'h00);
    step(1, 8'hFF);
    repeat (4) step(0, 8'h00);
    step(0, 8'h00, 1);
    chk("abort_mux_in", 32'(mi[0]), 32'h0FF);
    chk("abort_sel_valid", 32'(vr[0]), 32'd0);
    repeat (30) step(0, 8'h00);
    step(1, 8'h11);
    repeat (7) step(0, 8'h00);
    step(1, 8'h55, 1);
    chk("abort_final_noload", 32'(mi[0]), 32'h011);
    repeat (30) step(0, 8'h00);
    step(1, 8'h77);
    repeat (5) step(0, 8'h00);
    step(0, 8'h00, 0, 0);
    chk("rst_mux_in", 32'(mi[0]), 32'd0);
    step(1, 8'h99);
    chk("reload_sel", 32'(sl[0]), 32'd0);
    repeat (30) step(0, 8'h00);
    repeat (400) step($urandom_range(0, 3) != 0, 8'($urandom), $urandom_range(0, 15) == 0, $urandom_range(0, 63) != 0);
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
